// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: backward-path hazard control for the 5-stage pipeline.
// Generates PC / IF/ID / ID/EX stall, bubble and flush controls for load-use
// hazards, taken branch/jump redirects and data-memory wait freezes.
// Optional feature macro: HAZARD_PERF_CNT_EN enables saturating performance
// counters (stall_cnt, flush_cnt); when undefined both outputs are tied to 0.
module hazard_stall_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_src_1,
  input  logic [4:0]       id_src_2,
  input  logic             id_uses_src2,
  input  logic [4:0]       ex_dest,
  input  logic [1:0]       ex_MemRead,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_write_en,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  // Remaining-cycle preload values: the first stall/flush cycle happens in the
  // cycle that detects the event, so the dedicated state covers the rest.
  localparam logic [2:0] LU_REM    = 3'(LU_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_REM = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state, next_state;
  logic [2:0] rem, next_rem;
  logic       lu_hit;

  assign lu_hit = id_valid && (ex_MemRead != 2'b00) && (ex_dest != 5'd0) &&
                  ((ex_dest == id_src_1) || (id_uses_src2 && (ex_dest == id_src_2)));

  assign hz_state = state;

  // State and remaining-cycle register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= next_state;
      rem   <= next_rem;
    end
  end

  // Next-state and control decode: mem_busy > ex_redirect > load-use / state
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    idex_write_en = 1'b1;
    next_state    = state;
    next_rem      = rem;

    if (mem_busy) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_write_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = FLUSH;
        next_rem   = FLUSH_REM;
      end else begin
        next_state = RUN;
        next_rem   = 3'd0;
      end
    end else begin
      case (state)
        RUN: begin
          if (lu_hit) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              next_state = LU_STALL;
              next_rem   = LU_REM;
            end
          end
        end
        LU_STALL: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
          if (rem <= 3'd1) begin
            next_state = RUN;
            next_rem   = 3'd0;
          end else begin
            next_rem = rem - 3'd1;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (rem <= 3'd1) begin
            next_state = RUN;
            next_rem   = 3'd0;
          end else begin
            next_rem = rem - 3'd1;
          end
        end
        default: begin
          next_state = RUN;
          next_rem   = 3'd0;
        end
      endcase
    end

    if (!rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      idex_write_en = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt, flush_evt;

  // A load-use bubble is a bubble without a flush; both are ignored during a freeze
  assign stall_evt = !mem_busy && idex_bubble && !ifid_flush;
  assign flush_evt = !mem_busy && ifid_flush;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed bench for hazard_stall_ctrl with
// LU_STALL_CYCLES=2, FLUSH_CYCLES=2, CNT_W=4. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src_1;
  logic [4:0] id_src_2;
  logic       id_uses_src2;
  logic [4:0] ex_dest;
  logic [1:0] ex_MemRead;
  logic       ex_redirect;
  logic       mem_busy;
  logic       pc_write_en;
  logic       ifid_write_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       idex_write_en;
  logic [1:0] hz_state;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
  logic [4:0] ctrl;

  int errors = 0;
  int checks = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // Control bundle order: pc_write_en, ifid_write_en, ifid_flush, idex_bubble, idex_write_en
  localparam logic [4:0] C_NORM  = 5'b11001;
  localparam logic [4:0] C_RST   = 5'b00111;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_BUSY  = 5'b00000;

  assign ctrl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, idex_write_en};

  hazard_stall_ctrl #(
    .LU_STALL_CYCLES(2),
    .FLUSH_CYCLES   (2),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src_1     (id_src_1),
    .id_src_2     (id_src_2),
    .id_uses_src2 (id_uses_src2),
    .ex_dest      (ex_dest),
    .ex_MemRead   (ex_MemRead),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .pc_write_en  (pc_write_en),
    .ifid_write_en(ifid_write_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .idex_write_en(idex_write_en),
    .hz_state     (hz_state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the next falling edge and drive an idle (no-hazard) input set
  task automatic idle_inputs();
    @(negedge clk);
    id_valid     = 1'b0;
    id_src_1     = 5'd0;
    id_src_2     = 5'd0;
    id_uses_src2 = 1'b0;
    ex_dest      = 5'd0;
    ex_MemRead   = 2'b00;
    ex_redirect  = 1'b0;
    mem_busy     = 1'b0;
  endtask

  // Move to the next falling edge and present a load-use hit on rs (r5)
  task automatic lu_inputs();
    @(negedge clk);
    id_valid     = 1'b1;
    id_src_1     = 5'd5;
    id_src_2     = 5'd0;
    id_uses_src2 = 1'b0;
    ex_dest      = 5'd5;
    ex_MemRead   = 2'b01;
    ex_redirect  = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_RST) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_RST);
    end
    rst = 1'b1;
    idle_inputs();
    lu_inputs();
    idle_inputs();
    ex_MemRead = 2'b00;
    #1;
    checks++;
    if (hz_state !== 2'd1) begin
      errors++; $display("[TB] FAIL reset_pre_lustall_state: got %0d expected 1", hz_state);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_RST) begin
      errors++; $display("[TB] FAIL reset_async_ctrl: got %b expected %b", ctrl, C_RST);
    end
    checks++;
    if (hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_async_state: got %0d expected 0", hz_state);
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (hz_state !== 2'd0 || pc_write_en !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release: got state=%0d pc_we=%b expected state=0 pc_we=1", hz_state, pc_write_en);
    end
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    lu_inputs();
    #1;
    checks++;
    if (ctrl !== C_STALL || hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL lu_first: got ctrl=%b state=%0d expected ctrl=%b state=0", ctrl, hz_state, C_STALL);
    end
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_STALL || hz_state !== 2'd1) begin
      errors++; $display("[TB] FAIL lu_second: got ctrl=%b state=%0d expected ctrl=%b state=1", ctrl, hz_state, C_STALL);
    end
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_NORM || hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL lu_done: got ctrl=%b state=%0d expected ctrl=%b state=0", ctrl, hz_state, C_NORM);
    end
    checks++;
    if (stall_cnt !== 4'(2 * PERF)) begin
      errors++; $display("[TB] FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, 2 * PERF);
    end
    // Hit through rt with MemRead=2'b10
    idle_inputs();
    id_valid = 1'b1; id_src_1 = 5'd3; id_src_2 = 5'd7; id_uses_src2 = 1'b1;
    ex_dest = 5'd7; ex_MemRead = 2'b10;
    #1;
    checks++;
    if (ctrl !== C_STALL) begin
      errors++; $display("[TB] FAIL lu_src2: got %b expected %b", ctrl, C_STALL);
    end
    idle_inputs();
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || stall_cnt !== 4'(4 * PERF)) begin
      errors++; $display("[TB] FAIL lu_src2_done: got state=%0d cnt=%0d expected state=0 cnt=%0d", hz_state, stall_cnt, 4 * PERF);
    end
  endtask

  task automatic test_no_stall();
    idle_inputs();
    id_valid = 1'b1; id_src_1 = 5'd0; ex_dest = 5'd0; ex_MemRead = 2'b01;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL nostall_r0: got %b expected %b", ctrl, C_NORM);
    end
    idle_inputs();
    id_valid = 1'b1; id_src_1 = 5'd3; id_src_2 = 5'd9; id_uses_src2 = 1'b0;
    ex_dest = 5'd9; ex_MemRead = 2'b01;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL nostall_nosrc2: got %b expected %b", ctrl, C_NORM);
    end
    idle_inputs();
    id_valid = 1'b0; id_src_1 = 5'd5; ex_dest = 5'd5; ex_MemRead = 2'b01;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL nostall_invalid: got %b expected %b", ctrl, C_NORM);
    end
    idle_inputs();
    id_valid = 1'b1; id_src_1 = 5'd5; ex_dest = 5'd5; ex_MemRead = 2'b00;
    #1;
    checks++;
    if (ctrl !== C_NORM) begin
      errors++; $display("[TB] FAIL nostall_noload: got %b expected %b", ctrl, C_NORM);
    end
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL nostall_state: got %0d expected 0", hz_state);
    end
  endtask

  task automatic test_redirect();
    lu_inputs();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_FLUSH || hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL redir_first: got ctrl=%b state=%0d expected ctrl=%b state=0", ctrl, hz_state, C_FLUSH);
    end
    lu_inputs();
    #1;
    checks++;
    if (ctrl !== C_FLUSH || hz_state !== 2'd2) begin
      errors++; $display("[TB] FAIL redir_flush: got ctrl=%b state=%0d expected ctrl=%b state=2", ctrl, hz_state, C_FLUSH);
    end
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_NORM || hz_state !== 2'd0) begin
      errors++; $display("[TB] FAIL redir_done: got ctrl=%b state=%0d expected ctrl=%b state=0", ctrl, hz_state, C_NORM);
    end
    checks++;
    if (flush_cnt !== 4'(2 * PERF) || stall_cnt !== 4'(4 * PERF)) begin
      errors++; $display("[TB] FAIL redir_cnts: got flush=%0d stall=%0d expected %0d/%0d", flush_cnt, stall_cnt, 2 * PERF, 4 * PERF);
    end
    // Redirect arriving mid-LU_STALL aborts the stall
    lu_inputs();
    idle_inputs();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_FLUSH || hz_state !== 2'd1) begin
      errors++; $display("[TB] FAIL redir_abort: got ctrl=%b state=%0d expected ctrl=%b state=1", ctrl, hz_state, C_FLUSH);
    end
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd2) begin
      errors++; $display("[TB] FAIL redir_abort_next: got %0d expected 2", hz_state);
    end
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || flush_cnt !== 4'(4 * PERF) || stall_cnt !== 4'(5 * PERF)) begin
      errors++; $display("[TB] FAIL redir_abort_done: got state=%0d flush=%0d stall=%0d expected 0/%0d/%0d", hz_state, flush_cnt, stall_cnt, 4 * PERF, 5 * PERF);
    end
  endtask

  task automatic test_mem_busy();
    idle_inputs();
    ex_redirect = 1'b1;
    idle_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl !== C_BUSY || hz_state !== 2'd2) begin
        errors++; $display("[TB] FAIL busy_hold%0d: got ctrl=%b state=%0d expected ctrl=%b state=2", i, ctrl, hz_state, C_BUSY);
      end
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_FLUSH || hz_state !== 2'd2) begin
      errors++; $display("[TB] FAIL busy_resume: got ctrl=%b state=%0d expected ctrl=%b state=2", ctrl, hz_state, C_FLUSH);
    end
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || flush_cnt !== 4'(6 * PERF)) begin
      errors++; $display("[TB] FAIL busy_done: got state=%0d flush=%0d expected 0/%0d", hz_state, flush_cnt, 6 * PERF);
    end
    // Freeze outranks a load-use hit in RUN
    lu_inputs();
    mem_busy = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BUSY) begin
      errors++; $display("[TB] FAIL busy_over_lu: got %b expected %b", ctrl, C_BUSY);
    end
    idle_inputs();
    #1;
    checks++;
    if (hz_state !== 2'd0 || stall_cnt !== 4'(5 * PERF)) begin
      errors++; $display("[TB] FAIL busy_lu_state: got state=%0d stall=%0d expected 0/%0d", hz_state, stall_cnt, 5 * PERF);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1'b0;
    idle_inputs();
    rst = 1'b1;
    for (int ev = 1; ev <= 20; ev++) begin
      lu_inputs();
      idle_inputs();
      if (ev == 7) begin
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'(14 * PERF)) begin
          errors++; $display("[TB] FAIL sat_mid: got %0d expected %0d", stall_cnt, 14 * PERF);
        end
      end
    end
    idle_inputs();
    #1;
    checks++;
    if (stall_cnt !== 4'(15 * PERF) || flush_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL sat_final: got stall=%0d flush=%0d expected %0d/0", stall_cnt, flush_cnt, 15 * PERF);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst          = 1'b0;
    id_valid     = 1'b0;
    id_src_1     = 5'd0;
    id_src_2     = 5'd0;
    id_uses_src2 = 1'b0;
    ex_dest      = 5'd0;
    ex_MemRead   = 2'b00;
    ex_redirect  = 1'b0;
    mem_busy     = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_mem_busy();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
